// File: rtl/la_pkg.sv
// Shared types and helpers for the logic-analyzer capture core.
package la_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPreFill,
        StArmed,
        StPost,
        StDone
    } la_state_t;

    // Limit the pre-trigger count so at least the trigger sample fits in the buffer.
    function automatic int unsigned clamp_pre(input int unsigned pre, input int unsigned depth);
        return (pre > depth - 1) ? depth - 1 : pre;
    endfunction

endpackage

// File: rtl/la_capture_sdp_ram.sv
// Simple dual-port sample buffer: one write port, registered read port (BSRAM-style).
module la_sdp_ram #(
    parameter int unsigned W      = 88,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [W-1:0]      wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [W-1:0]      rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    // Array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyzer capture core: masked level/edge trigger, pre/post fill, chronological readout.
module la_capture_core
    import la_pkg::*;
#(
    parameter int unsigned PROBE_W = 88,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned ADDR_W  = $clog2(DEPTH)
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [PROBE_W-1:0] probe_i,
    input  logic               sample_en,
    input  logic               arm,
    input  logic               abort,
    input  logic               force_trig,
    input  logic [PROBE_W-1:0] trig_mask,
    input  logic [PROBE_W-1:0] trig_value,
    input  logic [PROBE_W-1:0] edge_mask,
    input  logic [ADDR_W-1:0]  pre_trig,
    input  logic [ADDR_W-1:0]  rd_idx,
    output logic [PROBE_W-1:0] rd_data,
    output logic               busy,
    output logic               triggered,
    output logic               done,
    output logic [ADDR_W-1:0]  trig_ptr
);

    localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    la_state_t          state_q, state_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [ADDR_W-1:0]  post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0]  trig_ptr_q, trig_ptr_d;
    logic               triggered_q, triggered_d;
    logic [PROBE_W-1:0] probe_prev_q, probe_prev_d;
    logic [PROBE_W-1:0] trig_mask_q, trig_mask_d;
    logic [PROBE_W-1:0] trig_value_q, trig_value_d;
    logic [PROBE_W-1:0] edge_mask_q, edge_mask_d;
    logic [ADDR_W-1:0]  pre_trig_q, pre_trig_d;

    logic              capturing;
    logic              we;
    logic              level_ok;
    logic              edge_ok;
    logic              hit;
    logic [ADDR_W-1:0] pre_cnt_inc;
    logic [ADDR_W-1:0] rd_start;
    logic [ADDR_W-1:0] rd_addr;

    assign capturing   = (state_q == StPreFill) || (state_q == StArmed) || (state_q == StPost);
    assign we          = capturing && sample_en;
    assign level_ok    = ((probe_i ^ trig_value_q) & trig_mask_q) == '0;
    assign edge_ok     = (edge_mask_q == '0) || (|((probe_i ^ probe_prev_q) & edge_mask_q));
    assign hit         = force_trig || (level_ok && edge_ok);
    assign pre_cnt_inc = pre_cnt_q + AddrOne;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        trig_ptr_d   = trig_ptr_q;
        triggered_d  = triggered_q;
        probe_prev_d = probe_prev_q;
        trig_mask_d  = trig_mask_q;
        trig_value_d = trig_value_q;
        edge_mask_d  = edge_mask_q;
        pre_trig_d   = pre_trig_q;

        if (we) begin
            wr_ptr_d     = wr_ptr_q + AddrOne;
            probe_prev_d = probe_i;
        end

        if (abort) begin
            state_d     = StIdle;
            triggered_d = 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (arm) begin
                        wr_ptr_d     = '0;
                        pre_cnt_d    = '0;
                        post_cnt_d   = '0;
                        triggered_d  = 1'b0;
                        probe_prev_d = '0;
                        trig_mask_d  = trig_mask;
                        trig_value_d = trig_value;
                        edge_mask_d  = edge_mask;
                        pre_trig_d   = ADDR_W'(clamp_pre(32'(pre_trig), DEPTH));
                        state_d      = (pre_trig_d == '0) ? StArmed : StPreFill;
                    end
                end
                StPreFill: begin
                    if (sample_en) begin
                        pre_cnt_d = pre_cnt_inc;
                        if (pre_cnt_inc == pre_trig_q) begin
                            state_d = StArmed;
                        end
                    end
                end
                StArmed: begin
                    if (sample_en && hit) begin
                        trig_ptr_d  = wr_ptr_q;
                        triggered_d = 1'b1;
                        post_cnt_d  = LastIdx - pre_trig_q;
                        state_d     = (post_cnt_d == '0) ? StDone : StPost;
                    end
                end
                StPost: begin
                    if (sample_en) begin
                        post_cnt_d = post_cnt_q - AddrOne;
                        if (post_cnt_q == AddrOne) begin
                            state_d = StDone;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            trig_ptr_q   <= '0;
            triggered_q  <= 1'b0;
            probe_prev_q <= '0;
            trig_mask_q  <= '0;
            trig_value_q <= '0;
            edge_mask_q  <= '0;
            pre_trig_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            trig_ptr_q   <= trig_ptr_d;
            triggered_q  <= triggered_d;
            probe_prev_q <= probe_prev_d;
            trig_mask_q  <= trig_mask_d;
            trig_value_q <= trig_value_d;
            edge_mask_q  <= edge_mask_d;
            pre_trig_q   <= pre_trig_d;
        end
    end

    // Oldest retained sample sits pre_trig entries before the trigger, modulo DEPTH.
    assign rd_start = trig_ptr_q - pre_trig_q;
    assign rd_addr  = rd_start + rd_idx;

    la_sdp_ram #(
        .W      (PROBE_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (probe_i),
        .re_i    (state_q == StDone),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign busy      = capturing;
    assign done      = (state_q == StDone);
    assign triggered = triggered_q;
    assign trig_ptr  = trig_ptr_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core with a readout scoreboard (PROBE_W=16, DEPTH=16).
module tb_la_capture_core;

    localparam int unsigned PW = 16;
    localparam int unsigned DP = 16;
    localparam int unsigned AW = 4;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic [PW-1:0] probe_i;
    logic          sample_en;
    logic          arm;
    logic          abort;
    logic          force_trig;
    logic [PW-1:0] trig_mask;
    logic [PW-1:0] trig_value;
    logic [PW-1:0] edge_mask;
    logic [AW-1:0] pre_trig;
    logic [AW-1:0] rd_idx;
    logic [PW-1:0] rd_data;
    logic          busy;
    logic          triggered;
    logic          done;
    logic [AW-1:0] trig_ptr;

    int errors = 0;
    int checks = 0;
    logic [PW-1:0] sb [$];
    logic [PW-1:0] ev [16];
    logic          early;

    always #5 sys_clk = ~sys_clk;

    la_capture_core #(
        .PROBE_W (PW),
        .DEPTH   (DP)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .probe_i    (probe_i),
        .sample_en  (sample_en),
        .arm        (arm),
        .abort      (abort),
        .force_trig (force_trig),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .edge_mask  (edge_mask),
        .pre_trig   (pre_trig),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .busy       (busy),
        .triggered  (triggered),
        .done       (done),
        .trig_ptr   (trig_ptr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge sys_clk);
    endtask

    task automatic cyc(input logic [PW-1:0] p, input logic en, input logic ft);
        probe_i    = p;
        sample_en  = en;
        force_trig = ft;
        step();
        force_trig = 1'b0;
    endtask

    // Configuration is scrambled after the arm cycle; the core must use the captured copy.
    task automatic do_arm(input logic [PW-1:0] m, input logic [PW-1:0] v,
                          input logic [PW-1:0] e, input logic [AW-1:0] pre);
        trig_mask  = m;
        trig_value = v;
        edge_mask  = e;
        pre_trig   = pre;
        sample_en  = 1'b0;
        arm        = 1'b1;
        step();
        arm        = 1'b0;
        trig_mask  = '0;
        trig_value = '0;
        edge_mask  = '0;
        pre_trig   = AW'($urandom);
        chk("arm_busy", 32'(busy), 32'd1);
        chk("arm_trig_clr", 32'(triggered), 32'd0);
    endtask

    task automatic readout(input logic [PW-1:0] exp_arr [16]);
        for (int i = 0; i < 16; i++) begin
            rd_idx    = AW'(i);
            probe_i   = PW'($urandom);
            sample_en = 1'b1;
            sb.push_back(exp_arr[i]);
            step();
            chk($sformatf("rd_idx%0d", i), 32'(rd_data), 32'(sb.pop_front()));
        end
        sample_en = 1'b0;
        chk("rd_done_hold", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst_n  = 1'b0;
        probe_i    = '0;
        sample_en  = 1'b0;
        arm        = 1'b0;
        abort      = 1'b0;
        force_trig = 1'b0;
        trig_mask  = '0;
        trig_value = '0;
        edge_mask  = '0;
        pre_trig   = '0;
        rd_idx     = '0;
        repeat (2) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_trig", 32'(triggered), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ptr", 32'(trig_ptr), 32'd0);
        chk("rst_rd", 32'(rd_data), 32'd0);
        sys_rst_n = 1'b1;
        step();

        // Ramp with level trigger on 20, four pre-trigger samples.
        do_arm(16'hffff, 16'd20, 16'h0, 4'd4);
        for (int k = 0; k < 32; k++) begin
            cyc(PW'(k), 1'b1, 1'b0);
            if (k == 19) chk("t1_pre_trig", 32'(triggered), 32'd0);
            if (k == 20) begin
                chk("t1_trig", 32'(triggered), 32'd1);
                chk("t1_ptr", 32'(trig_ptr), 32'd4);
            end
            if (k == 30) chk("t1_not_done", 32'(done), 32'd0);
            if (k == 31) begin
                chk("t1_done", 32'(done), 32'd1);
                chk("t1_idle_busy", 32'(busy), 32'd0);
            end
        end
        for (int i = 0; i < 16; i++) ev[i] = PW'(16 + i);
        readout(ev);

        // Edge trigger on bit 0 after 30 samples at 0.
        do_arm(16'h0, 16'h0, 16'h1, 4'd4);
        early = 1'b0;
        for (int k = 0; k < 42; k++) begin
            cyc(PW'((k << 1) | ((k >= 30) ? 1 : 0)), 1'b1, 1'b0);
            if (k < 30) early = early | triggered;
            if (k == 29) chk("t2_no_early", 32'(early), 32'd0);
            if (k == 30) begin
                chk("t2_trig", 32'(triggered), 32'd1);
                chk("t2_ptr", 32'(trig_ptr), 32'd14);
            end
            if (k == 40) chk("t2_not_done", 32'(done), 32'd0);
            if (k == 41) chk("t2_done", 32'(done), 32'd1);
        end
        for (int i = 0; i < 16; i++) ev[i] = PW'(((26 + i) << 1) | ((26 + i >= 30) ? 1 : 0));
        readout(ev);

        // Qualified every other cycle; a mid-capture arm must be ignored.
        do_arm(16'hffff, 16'd20, 16'h0, 4'd2);
        for (int c = 0; c < 47; c++) begin
            arm = (c == 6);
            cyc(PW'(c), (c % 2) == 0, 1'b0);
            arm = 1'b0;
            if (c == 18) chk("t3_pre_trig", 32'(triggered), 32'd0);
            if (c == 20) begin
                chk("t3_trig", 32'(triggered), 32'd1);
                chk("t3_ptr", 32'(trig_ptr), 32'd10);
            end
            if (c == 45) chk("t3_not_done", 32'(done), 32'd0);
            if (c == 46) chk("t3_done", 32'(done), 32'd1);
        end
        for (int i = 0; i < 16; i++) ev[i] = PW'(2 * (8 + i));
        readout(ev);

        // Forced trigger ignored in pre-fill, honoured when armed; pre_trig = DEPTH-1.
        do_arm(16'hffff, 16'hffff, 16'h0, 4'd15);
        for (int k = 0; k < 21; k++) begin
            cyc(PW'(k + 100), 1'b1, (k == 5) || (k == 20));
            if (k == 5) chk("t4_force_ignored", 32'(triggered), 32'd0);
            if (k == 19) chk("t4_still_busy", 32'(busy), 32'd1);
            if (k == 20) begin
                chk("t4_trig", 32'(triggered), 32'd1);
                chk("t4_done", 32'(done), 32'd1);
                chk("t4_ptr", 32'(trig_ptr), 32'd4);
            end
        end
        for (int i = 0; i < 16; i++) ev[i] = PW'(105 + i);
        readout(ev);

        // Abort mid-post, arm+abort together, then a wrapping capture.
        do_arm(16'hffff, 16'd8, 16'h0, 4'd4);
        for (int k = 0; k < 13; k++) begin
            abort = (k == 12);
            cyc(PW'(k), 1'b1, 1'b0);
            if (k == 8) chk("t5_trig", 32'(triggered), 32'd1);
        end
        abort = 1'b0;
        chk("t5_abort_busy", 32'(busy), 32'd0);
        chk("t5_abort_trig", 32'(triggered), 32'd0);
        chk("t5_abort_done", 32'(done), 32'd0);
        arm   = 1'b1;
        abort = 1'b1;
        step();
        arm   = 1'b0;
        abort = 1'b0;
        chk("t5_abort_wins", 32'(busy), 32'd0);
        do_arm(16'hffff, 16'h100 + 16'd40, 16'h0, 4'd3);
        for (int k = 0; k < 53; k++) begin
            cyc(PW'(16'h100 + k), 1'b1, 1'b0);
            if (k == 40) chk("t5_ptr", 32'(trig_ptr), 32'd8);
            if (k == 51) chk("t5_not_done", 32'(done), 32'd0);
            if (k == 52) chk("t5_done", 32'(done), 32'd1);
        end
        for (int i = 0; i < 16; i++) ev[i] = PW'(16'h100 + 37 + i);
        readout(ev);

        // Asynchronous reset while armed.
        do_arm(16'hffff, 16'hffff, 16'h0, 4'd2);
        for (int k = 0; k < 10; k++) cyc(PW'(k), 1'b1, 1'b0);
        #3 sys_rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        chk("t6_rst_trig", 32'(triggered), 32'd0);
        chk("t6_rst_ptr", 32'(trig_ptr), 32'd0);
        chk("t6_rst_rd", 32'(rd_data), 32'd0);
        step();
        sys_rst_n = 1'b1;
        step();
        do_arm(16'hffff, 16'h300, 16'h0, 4'd0);
        for (int k = 0; k < 16; k++) begin
            cyc(PW'(16'h300 + k), 1'b1, 1'b0);
            if (k == 0) begin
                chk("t6_trig_first", 32'(triggered), 32'd1);
                chk("t6_ptr", 32'(trig_ptr), 32'd0);
            end
            if (k == 14) chk("t6_not_done", 32'(done), 32'd0);
            if (k == 15) chk("t6_done", 32'(done), 32'd1);
        end
        for (int i = 0; i < 16; i++) ev[i] = PW'(16'h300 + i);
        readout(ev);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/la_capture_core.md
# la_capture_core

Parametrised on-chip logic-analyzer capture core for the dual-OV5640 splicing path. It samples a wide probe bus on `sys_clk` into a circular buffer and evaluates a masked level/edge trigger, with optional sample qualification (e.g. `pixel_href`). It then retains a programmable number of pre-trigger samples and fills the rest of the buffer post-trigger. The frozen capture is read back in chronological order through a simple indexed read port, which a host/JTAG-side register block will drive.

## Interface
Parameters:
- `PROBE_W`, 88, probe bus width in bits.
- `DEPTH`, 1024, buffer depth in samples; power of two, minimum 16.
- `ADDR_W`, $clog2(DEPTH), derived; not overridden.

Ports:
- `sys_clk`  in  1  single clock for all logic.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `probe_i`  in  PROBE_W  sampled signals.
- `sample_en`  in  1  qualifier; a sample is stored and triggers are evaluated only when high.
- `arm`  in  1  single-cycle start pulse.
- `abort`  in  1  single-cycle stop pulse; has priority over `arm`.
- `force_trig`  in  1  manual trigger.
- `trig_mask`  in  PROBE_W  level-compare enable per bit.
- `trig_value`  in  PROBE_W  level-compare value.
- `edge_mask`  in  PROBE_W  bits that must toggle between qualified samples.
- `pre_trig`  in  ADDR_W  number of pre-trigger samples; clamped to DEPTH-1.
- `rd_idx`  in  ADDR_W  chronological read index, 0 = oldest.
- `rd_data`  out  PROBE_W  sample at `rd_idx`, registered.
- `busy`  out  1  high in PRE_FILL, ARMED and POST.
- `triggered`  out  1  high from the trigger sample until the next arm or abort.
- `done`  out  1  high in DONE.
- `trig_ptr`  out  ADDR_W  physical address of the trigger sample.

## Operation
- States: IDLE, PRE_FILL, ARMED, POST, DONE.
- The block captures configuration inputs (`trig_*`, `edge_mask`, `pre_trig`) into registers on `arm`; changes to them mid-capture are ignored.
- IDLE/DONE + `arm`:
  - clear `wr_ptr`, counters, `triggered` and `probe_d`;
  - go to PRE_FILL, or straight to ARMED if `pre_trig`==0.
- PRE_FILL: write each qualified sample to `mem[wr_ptr]` and increment `wr_ptr`. Go to ARMED when the pre-count reaches `pre_trig`. Triggers are ignored in this state.
- ARMED: write qualified samples. On a qualified sample with `hit`:
  - latch `trig_ptr`=`wr_ptr` and set `triggered`;
  - load post-count = DEPTH-1-`pre_trig`;
  - go to POST, or DONE if the count is 0.
- `hit` = `force_trig` OR (`level_ok` AND `edge_ok`):
  - `level_ok` = `((probe_i ^ trig_value) & trig_mask) == 0`;
  - `edge_ok` = (`edge_mask`==0) OR `|((probe_i ^ probe_d) & edge_mask)`;
  - `probe_d` = last qualified sample, updated only on `sample_en`.
- POST: write qualified samples and decrement the post-count. At 0, go to DONE; the buffer is then frozen and writes stop.
- `wr_ptr` wraps modulo DEPTH. ARMED may run indefinitely, overwriting the oldest samples.
- Readout: `start = trig_ptr - pre_trig` (mod DEPTH), read address = `start + rd_idx` (mod DEPTH). `rd_data` is defined only in DONE and holds its previous value otherwise.
- `abort` in any state: go to IDLE, deassert `busy`/`done`/`triggered`.
- `arm` while busy: ignored. `arm` and `abort` in the same cycle: `abort` wins.

## Timing
- Reset values: state IDLE, `busy`=0, `triggered`=0, `done`=0, `trig_ptr`=0, `rd_data`=0, `wr_ptr`=0, `probe_d`=0.
- `arm` at cycle N: `busy`=1 at N+1. The first sample is written at N+1 if `sample_en` is high.
- Trigger sample at cycle T: `triggered`=1 at T+1 and `trig_ptr` is valid at T+1.
- The final post-trigger write at cycle F raises `done` at F+1. The RAM write at F has completed by F+1.
- `rd_data` latency: one cycle from `rd_idx`. RAM read is synchronous, with the output register inside the RAM.
- Exactly DEPTH samples are retained. The trigger sample is at `rd_idx` = `pre_trig`.

## Structure
- Package `la_pkg`: state enum `la_state_t` and the `clamp_pre` function.
- Sub-module `la_sdp_ram`: simple dual-port RAM (PROBE_W × DEPTH) with one write port, a registered read port and no reset on the array. It infers Gowin BSRAM.
- The core contains the FSM, counters, trigger compare and read address adder.

## Test plan
- DEPTH=16, `pre_trig`=4, ramp probe 0,1,2…, `trig_mask`=all-ones, `trig_value`=20 → `done`, `rd_idx` 0..15 returns 16..31, `rd_idx` 4 = 20.
- `edge_mask`=bit0, `trig_mask`=0, bit0 held 0 for 30 cycles then set to 1 → trigger on the first 1 sample; no earlier trigger.
- `sample_en` toggles every other cycle with a ramp → stored samples are only the qualified values; `trig_ptr` advances once per two cycles.
- `force_trig` in PRE_FILL, then in ARMED → first ignored, second triggers; `pre_trig`=DEPTH-1 gives `done` on the trigger cycle +1.
- `abort` mid-POST, then re-`arm` → IDLE next cycle with all flags 0; the new capture completes correctly with a wrapped `wr_ptr`.
- Async `sys_rst_n` low mid-ARMED → all outputs return to their reset values immediately; `arm` works after release.
